// File: rtl/hazard_stall_unit_pkg.sv
// Shared CPU definitions for the hazard/stall controller: FSM encoding,
// default multiply latency, register index width and counter sizing helper.
package hazard_stall_unit_pkg;

  typedef logic state_t;

  localparam state_t RUN       = 1'b0;
  localparam state_t MULT_WAIT = 1'b1;

  localparam int DEFAULT_MULT_LATENCY = 3;
  localparam int REG_ADDR_W           = 5;

  // A latency of 1 or 2 still needs one counter bit to keep the logic uniform.
  function automatic int mcnt_width(input int lat);
    return (lat < 2) ? 1 : $clog2(lat);
  endfunction

endpackage

// File: rtl/mult_busy_counter.sv
// Tracks a multiply occupying EX; busy is combinational from start, state and mcnt.
// Zero-cycle latency; asserts busy for MULT_LATENCY-1 cycles, then one release cycle.
module mult_busy_counter #(
  parameter int MULT_LATENCY = hazard_stall_unit_pkg::DEFAULT_MULT_LATENCY
) (
  input  logic clk,
  input  logic arst_n,
  input  logic start,
  output logic busy
);
  import hazard_stall_unit_pkg::*;

  localparam int         MW         = mcnt_width(MULT_LATENCY);
  localparam bit         MULTI      = (MULT_LATENCY > 1);
  localparam logic [MW-1:0] MCNT_INIT = MULTI ? MW'(MULT_LATENCY - 2) : '0;

  state_t        state;
  logic [MW-1:0] mcnt;

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      state <= RUN;
      mcnt  <= '0;
    end else begin
      case (state)
        RUN: begin
          if (start && MULTI) begin
            state <= MULT_WAIT;
            mcnt  <= MCNT_INIT;
          end
        end
        default: begin
          // mcnt==0 is the release cycle: ID/EX takes the next instruction.
          if (mcnt != '0) begin
            mcnt <= mcnt - MW'(1);
          end else begin
            state <= RUN;
          end
        end
      endcase
    end
  end

  always_comb begin
    busy = 1'b0;
    if (state == RUN) begin
      busy = start & MULTI;
    end else begin
      busy = (mcnt != '0);
    end
  end

endmodule

// File: rtl/hazard_stall_unit.sv
// Load-use / multi-cycle multiply stall controller beside ID/EX; outputs are
// combinational (zero latency), multiply stalls take priority over load-use bubbles.
module hazard_stall_unit #(
  parameter int MULT_LATENCY = hazard_stall_unit_pkg::DEFAULT_MULT_LATENCY,
  parameter int REG_ADDR_W   = hazard_stall_unit_pkg::REG_ADDR_W,
  parameter int CNT_W        = 16
) (
  input  logic                  clk,
  input  logic                  arst_n,
  input  logic [REG_ADDR_W-1:0] Rs1_IF_ID,
  input  logic [REG_ADDR_W-1:0] Rs2_IF_ID,
  input  logic [REG_ADDR_W-1:0] RegRd_ID_EX,
  input  logic                  MemRead_ID_EX,
  input  logic                  Mult_ID_EX,
  output logic                  PCWrite,
  output logic                  IF_ID_Write,
  output logic                  ID_EX_Write,
  output logic                  ID_EX_Bubble,
  output logic                  EX_MEM_Bubble,
  output logic                  mult_busy,
  output logic [CNT_W-1:0]      stall_count
);

  logic load_hz;
  logic busy;

  mult_busy_counter #(
    .MULT_LATENCY(MULT_LATENCY)
  ) u_mbc (
    .clk   (clk),
    .arst_n(arst_n),
    .start (Mult_ID_EX),
    .busy  (busy)
  );

  // x0 is hardwired zero, so a load targeting it never creates a dependency.
  assign load_hz = MemRead_ID_EX && (RegRd_ID_EX != '0) &&
                   ((RegRd_ID_EX == Rs1_IF_ID) || (RegRd_ID_EX == Rs2_IF_ID));

  assign mult_busy = busy;

  always_comb begin
    PCWrite       = 1'b1;
    IF_ID_Write   = 1'b1;
    ID_EX_Write   = 1'b1;
    ID_EX_Bubble  = 1'b0;
    EX_MEM_Bubble = 1'b0;
    if (busy) begin
      // EX is frozen, so ID/EX holds and EX/MEM receives bubbles.
      PCWrite       = 1'b0;
      IF_ID_Write   = 1'b0;
      ID_EX_Write   = 1'b0;
      EX_MEM_Bubble = 1'b1;
    end else if (load_hz) begin
      PCWrite       = 1'b0;
      IF_ID_Write   = 1'b0;
      ID_EX_Bubble  = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      stall_count <= '0;
    end else if (!PCWrite && (stall_count != '1)) begin
      stall_count <= stall_count + CNT_W'(1);
    end
  end

endmodule
